recip_scheduler: RTL and testbench
==================================

RECIP_SCHEDULER -- requirements
Module: recip_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one reciprocal engine.
REQ-002 SHALL have parameter ARG_BIT_WIDTH, default 32, meaning divisor width.
REQ-003 SHALL have parameter PRECISION, default 64, meaning reciprocal result width.
REQ-004 SHALL have parameter TIMEOUT, default 2*PRECISION+8, meaning watchdog limit in cycles.
REQ-005 SHALL have ports: clk  in  1  clock; all logic on posedge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 SHALL have ports: req_arg  in  NUM_REQ*ARG_BIT_WIDTH  packed divisors; slot i is requester i.
REQ-009 SHALL have ports: req_ready  out  NUM_REQ  one-hot grant/accept.
REQ-010 SHALL have ports: rsp_valid, rsp_ready, rsp_id, rsp_result, rsp_dvz, rsp_timeout  (out 1, in 1, out clog2(NUM_REQ), out PRECISION, out 1, out 1)  response channel.
REQ-011 SHALL have ports: eng_start, eng_arg  (out 1, out ARG_BIT_WIDTH)  engine launch pulse and operand.
REQ-012 SHALL have ports: eng_done, eng_result  (in 1, in PRECISION)  engine completion level and quotient.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-014 In IDLE with any req_valid, SHALL grant one requester round-robin, starting after the last granted index (index 0 first after reset).
REQ-015 The transfer SHALL occur in the cycle with req_valid[i] and req_ready[i] both high, capturing arg and id.
REQ-016 req_ready SHALL be high only in IDLE, only for the granted index, and never for more than one bit.
REQ-017 A captured arg of 0 SHALL go directly to RESP with rsp_dvz=1 and rsp_result=0; no eng_start is issued.
REQ-018 A nonzero arg SHALL go to LAUNCH, which asserts eng_start for exactly one cycle, then moves to WAIT.
REQ-019 eng_arg SHALL equal the captured arg from LAUNCH through the end of WAIT.
REQ-020 WAIT SHALL ignore eng_done until eng_done has been sampled low at least once after launch, masking a stale done level.
REQ-021 On a qualified eng_done, SHALL register eng_result into rsp_result and go to RESP.
REQ-022 A watchdog SHALL count WAIT cycles; on reaching TIMEOUT it SHALL go to RESP with rsp_timeout=1 and rsp_result=0.
REQ-023 In RESP, rsp_valid=1 and rsp_* SHALL stay stable until rsp_ready; on handshake, return to IDLE.
REQ-024 Request-to-rsp_valid latency SHALL be: 1 cycle for a dvz request; engine latency + 2 cycles otherwise.
REQ-025 Only one operation SHALL be in flight; new requests are held off (req_ready=0) outside IDLE.
REQ-026 A requester dropping req_valid before handshake SHALL lose the grant without penalty; the pointer does not advance.
REQ-027 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, pointer=0, and all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_result, rsp_dvz, rsp_timeout, eng_start, eng_arg).
REQ-029 Reset mid-operation SHALL abandon the in-flight request with no response; the engine result is discarded.

Structure
REQ-030 Shared package recip_pkg SHALL hold ARG_BIT_WIDTH, PRECISION, and the FSM state enum.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on accept).

Verification
REQ-032 Single requester 0, arg 0x13, engine done after 65 cycles -> one eng_start pulse, rsp_id=0, rsp_result=engine value, latency 67.
REQ-033 All four requesters valid simultaneously, args 2/3/5/7 -> responses in order of id 0,1,2,3; then requester 0 again after 3.
REQ-034 Requester 2, arg 0 -> rsp_dvz=1, rsp_result=0, latency 1 cycle, eng_start never asserted.
REQ-035 eng_done held high from the prior op, then low 1 cycle, then high -> completion only on the second rise.
REQ-036 eng_done never asserted -> rsp_timeout=1 after 136 WAIT cycles; rsp_ready held low for 5 cycles -> outputs stable.
REQ-037 rst_n pulsed low during WAIT -> all outputs 0 immediately, no response emitted, next request served normally.

Source files
------------

// File: rtl/recip_pkg.sv
// Shared defaults and FSM encoding for the reciprocal-engine scheduler.
package recip_pkg;

   localparam int ARG_BIT_WIDTH = 32;
   localparam int PRECISION     = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/recip_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last accepted index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          accept,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr;
   logic [IW:0]   sum;

   // Scan from the farthest offset down so the closest requester to ptr wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      sum       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
         if (req[sum[IW-1:0]]) begin
            grant              = '0;
            grant[sum[IW-1:0]] = 1'b1;
            grant_idx          = sum[IW-1:0];
         end
      end
   end

   // Pointer only moves on a completed transfer, so a withdrawn request costs nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr <= '0;
      else if (accept) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/recip_scheduler.sv
// Shares one multi-cycle reciprocal engine among NUM_REQ requesters, one op at a time,
// with divide-by-zero bypass, stale-done masking and a WAIT watchdog.
module recip_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int ARG_BIT_WIDTH = recip_pkg::ARG_BIT_WIDTH,
   parameter int PRECISION     = recip_pkg::PRECISION,
   parameter int TIMEOUT       = 2 * PRECISION + 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ARG_BIT_WIDTH-1:0] req_arg,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
   output logic [PRECISION-1:0]             rsp_result,
   output logic                             rsp_dvz,
   output logic                             rsp_timeout,
   output logic                             eng_start,
   output logic [ARG_BIT_WIDTH-1:0]         eng_arg,
   input  logic                             eng_done,
   input  logic [PRECISION-1:0]             eng_result
);

   import recip_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int CW   = $clog2(TIMEOUT + 1);

   state_t                                  state, state_nxt;
   logic                                    run;
   logic [NUM_REQ-1:0][ARG_BIT_WIDTH-1:0]   args;
   logic [NUM_REQ-1:0]                      grant;
   logic [ID_W-1:0]                         grant_idx;
   logic [ARG_BIT_WIDTH-1:0]                sel_arg;
   logic                                    accept;
   logic                                    seen_low;
   logic                                    done_ok;
   logic [CW-1:0]                           wdog;
   logic                                    wdog_hit;

   assign args     = req_arg;
   assign sel_arg  = args[grant_idx];
   // run keeps req_ready low while rst_n is asserted even if requesters are valid.
   assign req_ready = (run && state == ST_IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign done_ok   = seen_low & eng_done;
   assign wdog_hit  = (wdog == CW'(TIMEOUT - 1));
   assign eng_start = (state == ST_LAUNCH);
   assign rsp_valid = (state == ST_RESP);

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (accept) state_nxt = (sel_arg == '0) ? ST_RESP : ST_LAUNCH;
         ST_LAUNCH: state_nxt = ST_WAIT;
         ST_WAIT:   if (done_ok || wdog_hit) state_nxt = ST_RESP;
         ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // A done level left over from the previous op only counts after it has been seen low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_arg     <= '0;
         rsp_id      <= '0;
         rsp_result  <= '0;
         rsp_dvz     <= 1'b0;
         rsp_timeout <= 1'b0;
         seen_low    <= 1'b0;
         wdog        <= '0;
      end else begin
         if (accept) begin
            eng_arg     <= sel_arg;
            rsp_id      <= grant_idx;
            rsp_dvz     <= (sel_arg == '0);
            rsp_timeout <= 1'b0;
            rsp_result  <= '0;
         end
         if (state == ST_LAUNCH) begin
            seen_low <= 1'b0;
            wdog     <= '0;
         end
         if (state == ST_WAIT) begin
            if (!eng_done) seen_low <= 1'b1;
            wdog <= wdog + CW'(1);
            if (done_ok)       rsp_result  <= eng_result;
            else if (wdog_hit) rsp_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_recip_scheduler.sv
// Directed + randomized bench for recip_scheduler with a round-robin/latency reference model.
module tb_recip_scheduler;

   localparam int N       = 4;
   localparam int AW      = 32;
   localparam int PW      = 64;
   localparam int IW      = $clog2(N);
   localparam int TIMEOUT = 2 * PW + 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_arg;
   logic [N-1:0]      req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [PW-1:0]     rsp_result;
   logic              rsp_dvz;
   logic              rsp_timeout;
   logic              eng_start;
   logic [AW-1:0]     eng_arg;
   logic              eng_done;
   logic [PW-1:0]     eng_result;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ptr_m   = 0;

   recip_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_arg     (req_arg),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_dvz     (rsp_dvz),
      .rsp_timeout (rsp_timeout),
      .eng_start   (eng_start),
      .eng_arg     (eng_arg),
      .eng_done    (eng_done),
      .eng_result  (eng_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [PW-1:0] recip(input logic [AW-1:0] d);
      logic [PW-1:0] ones;
      ones = '1;
      return (d == '0) ? '0 : ones / PW'(d);
   endfunction

   task automatic set_arg(input int i, input logic [AW-1:0] v);
      req_arg[i*AW +: AW] = v;
   endtask

   // Serves one request end to end. lat = engine cycles from eng_start to done
   // (0 = engine never finishes), stale = done held high into the op, hold = rsp_ready delay.
   task automatic serve(input int lat, input bit stale, input int hold);
      int exp_id, got_id, hs_c, s, starts, exp_lat;
      bit hs, bad_ready, bad_arg;
      logic [AW-1:0] arg;
      logic [PW-1:0] exp_res, eng_val;
      logic [PW+IW+2:0] snap_exp;
      exp_id = rr_pick(req_valid, ptr_m);
      hs = 0; got_id = 0; hs_c = 0;
      for (int k = 0; k < 8 && !hs; k++) begin
         #1;
         if ((req_valid & req_ready) != '0) begin
            hs = 1; hs_c = cyc;
            for (int i = 0; i < N; i++) if (req_ready[i]) got_id = i;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("handshake", hs, 1);
      if (!hs) return;
      chk("grant_onehot", req_ready, N'(1) << exp_id);
      chk("grant_id", got_id, exp_id);
      arg     = req_arg[got_id*AW +: AW];
      eng_val = recip(arg);
      exp_res = (lat == 0) ? '0 : eng_val;
      exp_lat = (arg == '0) ? 1 : (lat == 0) ? TIMEOUT + 2 : lat + 2;
      s = -1; starts = 0; bad_ready = 0; bad_arg = 0;
      @(posedge clk); #1;
      req_valid[got_id] = 1'b0;
      for (int k = 0; k < TIMEOUT + 40; k++) begin
         if (s >= 0) begin
            eng_done   = (lat > 0 && cyc - s >= lat) || (stale && cyc - s < lat - 1);
            eng_result = eng_val;
         end
         #1;
         if (eng_start) begin
            starts++;
            if (s < 0) s = cyc;
         end
         if (s >= 0 && !rsp_valid && eng_arg !== arg) bad_arg = 1;
         if (rsp_valid) break;
         if (req_ready != '0) bad_ready = 1;
         @(posedge clk); #1;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, got_id);
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_dvz", rsp_dvz, arg == '0);
      chk("rsp_timeout", rsp_timeout, arg != '0 && lat == 0);
      chk("latency", cyc - hs_c, exp_lat);
      chk("eng_starts", starts, (arg == '0) ? 0 : 1);
      chk("busy_ready_low", bad_ready, 0);
      chk("eng_arg_stable", bad_arg, 0);
      snap_exp = {1'b1, IW'(got_id), arg == '0, arg != '0 && lat == 0, exp_res};
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #2;
         chk("rsp_hold", {rsp_valid, rsp_id, rsp_dvz, rsp_timeout, rsp_result}, snap_exp);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      eng_done  = 1'b0;
      #1;
      chk("rsp_release", rsp_valid, 0);
      ptr_m = (got_id + 1) % N;
   endtask

   initial begin
      int  r;
      bit  got, seen;
      req_valid  = '1;
      req_arg    = '0;
      for (int i = 0; i < N; i++) set_arg(i, $urandom);
      rsp_ready  = 1'b0;
      eng_done   = 1'b0;
      eng_result = '0;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_dvz, rsp_timeout}, 0);
      chk("rst_eng", {eng_start, eng_arg}, 0);
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk); #1;

      // All four at once: ids 0..3 in order, then 0 again ahead of 2 after the wrap.
      set_arg(0, 2); set_arg(1, 3); set_arg(2, 5); set_arg(3, 7);
      req_valid = '1;
      for (int i = 0; i < N; i++) serve($urandom_range(2, 20), 0, 0);
      set_arg(0, 11); set_arg(2, 13);
      req_valid = 4'b0101;
      serve($urandom_range(2, 20), 0, 0);
      serve($urandom_range(2, 20), 0, 1);

      req_valid = 4'b0001; set_arg(0, 32'h13);
      serve(65, 0, 0);

      req_valid = 4'b0100; set_arg(2, 0);
      serve(5, 0, 0);

      eng_done  = 1'b1;
      req_valid = 4'b0010; set_arg(1, $urandom | 32'h1);
      serve(4, 1, 0);

      req_valid = 4'b1000; set_arg(3, $urandom | 32'h1);
      serve(0, 0, 5);

      // A requester that withdraws before the transfer must not move the pointer.
      r = (ptr_m + 2) % N;
      req_valid = '0; req_valid[r] = 1'b1;
      #1;
      chk("drop_ready", req_ready, N'(1) << r);
      req_valid = '0;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) set_arg(i, $urandom | 32'h1);
      req_valid = '1;
      serve($urandom_range(2, 30), 0, 0);

      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               set_arg(i, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
            end
         end
         if (req_valid == '0) begin
            r = $urandom_range(0, N - 1);
            req_valid[r] = 1'b1;
            set_arg(r, $urandom);
         end
         serve($urandom_range(2, 30), 0, $urandom_range(0, 3));
      end

      // Reset during WAIT abandons the op; the engine finishing meanwhile is ignored.
      req_valid = '0;
      set_arg(3, $urandom | 32'h1);
      req_valid[3] = 1'b1;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         #1;
         if (req_ready[3]) got = 1;
         else @(posedge clk);
      end
      chk("rst_test_handshake", got, 1);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_dvz, rsp_timeout}, 0);
      chk("midrst_eng", {eng_start, eng_arg}, 0);
      eng_done   = 1'b1;
      eng_result = {$urandom, $urandom};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ptr_m = 0;
      seen  = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #2;
         if (rsp_valid) seen = 1;
      end
      chk("no_rsp_after_reset", seen, 0);
      eng_done = 1'b0;
      set_arg(1, $urandom | 32'h1); set_arg(3, $urandom | 32'h1);
      req_valid = 4'b1010;
      serve($urandom_range(2, 30), 0, 0);
      req_valid = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
